// File: rtl/vec_lsu_pkg.sv
// Shared types and sizing helpers for the vector load/store sequencer.
package vec_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lsuState_t;

  localparam int unsigned DEF_VECTOR_SIZE   = 4;
  localparam int unsigned DEF_REGISTER_SIZE = 8;
  localparam int unsigned LANE_CNT_W        = $clog2(DEF_VECTOR_SIZE);

  typedef logic [DEF_VECTOR_SIZE-1:0][DEF_REGISTER_SIZE-1:0] laneVec_t;

  // A single-lane build still needs a one-bit counter.
  function automatic int unsigned laneCntWidth(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vec_lsu_agu.sv
// Lane address generator: loads the base at acceptance, then adds the stride once per issued lane.
module vec_lsu_agu #(
  parameter int unsigned addrWidth   = 16,
  parameter int unsigned strideWidth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic [addrWidth-1:0]   base,
  input  logic [strideWidth-1:0] stride,
  output logic [addrWidth-1:0]   addr
);

  logic [addrWidth-1:0] addrReg;

  // Addition wraps naturally modulo 2^addrWidth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrReg <= '0;
    end else if (load) begin
      addrReg <= base;
    end else if (step) begin
      addrReg <= addrReg + addrWidth'(stride);
    end
  end

  assign addr = addrReg;

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store sequencer: one lane per cycle onto a single-lane synchronous memory.
// Optional per-lane enables are built in when VEC_LSU_MASK_EN is defined.
module vec_lsu
  import vec_lsu_pkg::*;
#(
  parameter int unsigned registerSize = 8,
  parameter int unsigned vectorSize   = 4,
  parameter int unsigned addrWidth    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_write,
  input  logic [addrWidth-1:0]                    req_base,
  input  logic [registerSize-1:0]                 req_stride,
  input  logic [vectorSize-1:0][registerSize-1:0] req_data,
`ifdef VEC_LSU_MASK_EN
  input  logic [vectorSize-1:0]                   req_mask,
`endif
  output logic                                    busy,
  output logic                                    mem_en,
  output logic                                    mem_we,
  output logic [addrWidth-1:0]                    mem_addr,
  output logic [registerSize-1:0]                 mem_wdata,
  input  logic [registerSize-1:0]                 mem_rdata,
  output logic                                    resp_valid,
  output logic [vectorSize-1:0][registerSize-1:0] resp_data
);

  localparam int unsigned CNT_W = laneCntWidth(vectorSize);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(vectorSize - 1);

  lsuState_t stateReg, stateNext;

  logic                                    writeReg;
  logic [registerSize-1:0]                 strideReg;
  logic [vectorSize-1:0][registerSize-1:0] dataReg;
  logic [vectorSize-1:0][registerSize-1:0] respDataReg;
  logic [CNT_W-1:0]                        laneCnt;
  logic [vectorSize-1:0]                   laneMask;
  logic                                    accept;
  logic                                    issuing;

  // Read data arrives one cycle after issue, so remember which lane it belongs to.
  logic             pendValid;
  logic             pendEn;
  logic [CNT_W-1:0] pendLane;

  assign accept  = req_valid && (stateReg == IDLE);
  assign issuing = (stateReg == ISSUE);

`ifdef VEC_LSU_MASK_EN
  logic [vectorSize-1:0] maskReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maskReg <= '0;
    end else if (accept) begin
      maskReg <= req_mask;
    end
  end

  assign laneMask = maskReg;
`else
  assign laneMask = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    req_ready  = 1'b0;
    busy       = 1'b1;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) stateNext = ISSUE;
      end
      ISSUE: begin
        mem_en    = laneMask[laneCnt];
        mem_we    = writeReg;
        mem_wdata = dataReg[laneCnt];
        if (laneCnt == LAST_LANE) stateNext = writeReg ? DONE : DRAIN;
      end
      DRAIN: stateNext = DONE;
      DONE: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeReg  <= 1'b0;
      strideReg <= '0;
      dataReg   <= '0;
      laneCnt   <= '0;
    end else if (accept) begin
      writeReg  <= req_write;
      strideReg <= req_stride;
      dataReg   <= req_data;
      laneCnt   <= '0;
    end else if (issuing) begin
      laneCnt   <= laneCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendValid <= 1'b0;
      pendEn    <= 1'b0;
      pendLane  <= '0;
    end else begin
      pendValid <= issuing && !writeReg;
      pendEn    <= laneMask[laneCnt];
      pendLane  <= laneCnt;
    end
  end

  // Disabled lanes of a load are cleared so every lane is overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      respDataReg <= '0;
    end else if (pendValid) begin
      respDataReg[pendLane] <= pendEn ? mem_rdata : '0;
    end
  end

  assign resp_data = respDataReg;

  vec_lsu_agu #(
    .addrWidth  (addrWidth),
    .strideWidth(registerSize)
  ) u_agu (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (issuing),
    .base  (req_base),
    .stride(strideReg),
    .addr  (mem_addr)
  );

endmodule
